kbd_mmio: RTL
=============

Name: kbd_mmio

Overview:
- PS/2 keyboard receiver with a scan-code FIFO, mapped at the 0xe keyboard region of the CPU memory map.
- Samples the PS/2 clock and data lines and deframes 11-bit frames into 8-bit scan codes.
- Buffers the codes and presents a data word and a status word to the data-memory read mux, which drives them onto dmem_data_out.
- Sits directly downstream of the PS/2 pins and upstream of the CPU data-read path.

Parameters:
FIFO_DEPTH, 16, scan-code FIFO entries; power of two, 2..256.
TIMEOUT_CYCLES, 20000, clk cycles without a PS/2 falling edge before a partial frame is aborted.
SYNC_STAGES, 2, flip-flop synchronizer depth on ps2_clk and ps2_data.

Ports:
clk  in  1  system clock (same domain as clk_pipeline).
rst  in  1  reset; asynchronous, active-high.
ps2_clk  in  1  raw PS/2 clock line (asynchronous).
ps2_data  in  1  raw PS/2 data line (asynchronous).
rd_en  in  1  CPU read of the keyboard region; dmem_read_in qualified by dmem_addr[29:26]==4'he.
rd_sel  in  1  word select, from dmem_addr[0]: 0 = data word, 1 = status word.
rd_data  out  32  read word; combinational from rd_sel and current state.
kbd_overflow  out  1  sticky overflow flag (debug LED).

Behaviour:
Input sampling
- ps2_clk and ps2_data each pass through a SYNC_STAGES synchronizer.
- A PS/2 falling edge is detected when the previous synced clock is 1 and the current one is 0.
- All frame logic advances only on a detected falling edge.

Receive FSM (IDLE, DATA, PARITY, STOP)
- IDLE: on falling edge with data==0 (start bit), go to DATA with bit_cnt=0. Falling edge with data==1 is ignored.
- DATA: shift data in LSB first; after 8 bits go to PARITY.
- PARITY: capture parity bit; go to STOP.
- STOP: on falling edge, return to IDLE. The frame is accepted iff stop==1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
  - Rejected frame: set parity_err sticky flag; nothing is pushed.
- Timeout: in any non-IDLE state, a counter counts clk cycles since the last falling edge. Reaching TIMEOUT_CYCLES forces IDLE and discards the partial frame; no flag is set.

FIFO
- Accepted code is pushed one clk after the stop-bit edge.
- Push while full: code dropped, overflow sticky flag set, contents unchanged.
- Pop occurs only on the rising edge of the read strobe: rd_en=1, rd_sel=0, and the registered rd_en_d=0. This makes a read held across pipeline stalls pop exactly once.
- Pop while empty: no effect.
- Simultaneous push and pop: both take effect; count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

rd_data
- Data word (rd_sel=0): {24'b0, head} when non-empty, else 32'h0.
- Status word (rd_sel=1): bit0 non-empty, bit1 full, bit2 overflow, bit3 parity_err, bits[23:16] count, other bits 0.
- Status read rising edge (rd_en=1, rd_sel=1, rd_en_d=0) clears overflow and parity_err at the next clk. A flag event in the same cycle wins: the flag stays 1.

Reset
- Asynchronous. Forces FSM to IDLE, FIFO empty, pointers, count and flags to 0, rd_en_d=0, synchronizers to 1 (idle line).
- Resulting outputs: rd_data=0 for both selects; kbd_overflow=0.
- Reset mid-frame discards the frame.

Optional Feature:
KBD_IRQ_EN
- Defined: adds output kbd_irq (1 bit), registered, equal to FIFO non-empty; reset value 0. It deasserts one clk after the pop that empties the FIFO.
- Undefined: no kbd_irq port; behaviour otherwise identical.

Test Plan:
- Frame for 0x1C with parity 0, stop 1 -> status 32'h00010001; data read returns 32'h0000001C; status then reads 32'h0.
- Frame 0x1C with parity 1 -> nothing pushed; status bit3=1; a second status read returns 0.
- 17 valid frames with FIFO_DEPTH=16 -> status 32'h00100007 (count 16, full, non-empty, overflow); 16 data reads return codes 1..16 in order.
- rd_en held high for 5 cycles with rd_sel=0 and 2 entries -> exactly one pop; count goes 2->1.
- Start bit plus 3 data bits, then TIMEOUT_CYCLES idle, then valid frame 0xF0 -> only 0xF0 in FIFO; parity_err=0.
- rst asserted mid-frame with 3 entries queued -> immediate empty; status 0; the following valid frame is received normally.

Source files
------------

// File: rtl/kbd_mmio_if.sv
// -----------------------------------------------------------------------------
// kbd_mmio_if
// CPU read-side bus of the keyboard region.
//   rd_en   : CPU read strobe for the keyboard region
//   rd_sel  : word select, 0 = data word, 1 = status word
//   rd_data : 32-bit read word returned to the data-memory read mux
// Modports: master (CPU side) drives rd_en/rd_sel, slave (kbd_mmio) drives rd_data.
// -----------------------------------------------------------------------------
interface kbd_mmio_if;
    logic        rd_en;
    logic        rd_sel;
    logic [31:0] rd_data;

    modport master (output rd_en, output rd_sel, input rd_data);
    modport slave  (input rd_en, input rd_sel, output rd_data);
endinterface

// File: rtl/kbd_mmio.sv
// -----------------------------------------------------------------------------
// kbd_mmio
// PS/2 keyboard receiver with a scan-code FIFO for the 0xe keyboard region.
// Deframes 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop),
// queues accepted scan codes and exposes a data word and a status word.
//
// Ports:
//   clk            : system clock
//   rst            : asynchronous active-high reset
//   i_ps2_clk      : raw PS/2 clock line (asynchronous)
//   i_ps2_data     : raw PS/2 data line (asynchronous)
//   bus            : kbd_mmio_if.slave (rd_en, rd_sel in; rd_data out)
//   o_kbd_overflow : sticky FIFO overflow flag
//   o_kbd_irq      : registered FIFO non-empty (only with KBD_IRQ_EN defined)
//
// Optional feature macro: KBD_IRQ_EN (adds o_kbd_irq).
// -----------------------------------------------------------------------------
module kbd_mmio #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_ps2_clk,
    input  logic      i_ps2_data,
    kbd_mmio_if.slave bus,
    output logic      o_kbd_overflow
`ifdef KBD_IRQ_EN
    ,
    output logic      o_kbd_irq
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Frame is good when data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   w_ps2_clk;
    logic                   w_ps2_data;
    logic                   w_fall;

    state_t                 r_state;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic [TW-1:0]          r_to_cnt;
    logic                   r_push_v;
    logic [7:0]             r_push_code;
    logic                   r_perr_evt;

    logic [7:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_overflow;
    logic                   r_parity_err;
    logic                   r_rd_en_d;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push_ok;
    logic                   w_ovf_evt;
    logic                   w_stat_clr;
    logic [15:0]            w_cnt_ext;
    logic [31:0]            w_rd_data;

    assign w_ps2_clk  = r_clk_sync[SYNC_STAGES-1];
    assign w_ps2_data = r_data_sync[SYNC_STAGES-1];
    assign w_fall     = r_clk_prev & ~w_ps2_clk;

    // Synchronizers for the asynchronous PS/2 lines, idle-high after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync[0]  <= i_ps2_clk;
            r_data_sync[0] <= i_ps2_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_clk_sync[i]  <= r_clk_sync[i-1];
                r_data_sync[i] <= r_data_sync[i-1];
            end
            r_clk_prev <= w_ps2_clk;
        end
    end

    // Receive FSM: deframes bits on PS/2 falling edges, aborts on timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_par       <= 1'b0;
            r_to_cnt    <= '0;
            r_push_v    <= 1'b0;
            r_push_code <= 8'h00;
            r_perr_evt  <= 1'b0;
        end else begin
            r_push_v   <= 1'b0;
            r_perr_evt <= 1'b0;

            // Idle-gap counter only runs inside a frame; any edge restarts it.
            if ((r_state != S_IDLE) && !w_fall) begin
                if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_state  <= S_IDLE;
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end

            if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_ps2_data) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        r_shift   <= {w_ps2_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_par   <= w_ps2_data;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (w_ps2_data && odd_parity_ok(r_shift, r_par)) begin
                            r_push_v    <= 1'b1;
                            r_push_code <= r_shift;
                        end else begin
                            r_perr_evt <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_empty    = (r_count == CW'(0));
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    // Pop only on the first cycle of a data read so a stalled read pops once.
    assign w_pop      = bus.rd_en & ~bus.rd_sel & ~r_rd_en_d & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push_ok  = r_push_v & (~w_full | w_pop);
    assign w_ovf_evt  = r_push_v & w_full & ~w_pop;
    assign w_stat_clr = bus.rd_en & bus.rd_sel & ~r_rd_en_d;

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_push_code;
        end
    end

    // FIFO pointers, count, sticky flags and read-strobe history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_parity_err <= 1'b0;
            r_rd_en_d    <= 1'b0;
        end else begin
            r_rd_en_d <= bus.rd_en;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // New flag events take priority over a status-read clear.
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (w_stat_clr) begin
                r_overflow <= 1'b0;
            end
            if (r_perr_evt) begin
                r_parity_err <= 1'b1;
            end else if (w_stat_clr) begin
                r_parity_err <= 1'b0;
            end
        end
    end

    assign w_cnt_ext = 16'(r_count);

    // Read mux: data word (head of FIFO) or status word.
    always_comb begin
        w_rd_data = 32'h0000_0000;
        if (bus.rd_sel) begin
            w_rd_data[0]     = ~w_empty;
            w_rd_data[1]     = w_full;
            w_rd_data[2]     = r_overflow;
            w_rd_data[3]     = r_parity_err;
            w_rd_data[23:16] = w_cnt_ext[7:0];
        end else if (!w_empty) begin
            w_rd_data = {24'h00_0000, r_mem[r_rd_ptr]};
        end else begin
            w_rd_data = 32'h0000_0000;
        end
    end

    assign bus.rd_data    = w_rd_data;
    assign o_kbd_overflow = r_overflow;

`ifdef KBD_IRQ_EN
    logic r_irq;

    // Interrupt follows FIFO occupancy one clock late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= ~w_empty;
        end
    end

    assign o_kbd_irq = r_irq;
`endif

endmodule
